arb_requester: RTL

//  Requester-side agent for the 2-way round-robin arbiter (one instance per arbiter port).

---
 rtl/arb_requester_if.sv | 27 ++
 rtl/arb_requester.sv | 114 +++++++++++
 2 files changed

// File: rtl/arb_requester_if.sv
// Bundles the requester-side handshake and shared-bus signals.
// master: the requester agent. slave: the upstream source and arbiter side.
interface arb_requester_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic                     req;
    logic                     grant;
    logic                     bus_valid;
    logic [DATA_W-1:0]        bus_data;
    logic [$clog2(DEPTH):0]   pending;
    logic                     starve;
    logic                     spurious;

    modport master (
        input  in_valid, in_data, grant,
        output in_ready, req, bus_valid, bus_data, pending, starve, spurious
    );

    modport slave (
        output in_valid, in_data, grant,
        input  in_ready, req, bus_valid, bus_data, pending, starve, spurious
    );
endinterface

// File: rtl/arb_requester.sv
// Requester-side agent for a 2-way round-robin arbiter.
// Buffers upstream words in a FIFO, requests while work is pending, pops one
// word per grant pulse onto the shared bus, and flags starvation and
// spurious grants.
module arb_requester #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic           clk,
    input  logic           reset,
    arb_requester_if.master port
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              bus_valid_q, bus_valid_d;
    logic [DATA_W-1:0] bus_data_q, bus_data_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic              starve_q, starve_d;
    logic              spurious_q, spurious_d;

    logic full;
    logic push;
    logic pop;
    logic req;

    assign full = (count_q == CW'(DEPTH));
    // Full blocks a push even when a pop happens in the same cycle.
    assign push = port.in_valid && !reset && !full;
    assign pop  = port.grant && (count_q != '0);
    // Dropping req when the last word is being granted avoids a second grant
    // from the arbiter, which registers its grant one cycle after sampling req.
    assign req  = !reset && (count_q > CW'(port.grant));

    // Next-state computation for pointers, occupancy, bus and status flags.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        bus_valid_d  = 1'b0;
        bus_data_d   = bus_data_q;
        spurious_d   = spurious_q;
        starve_cnt_d = '0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + AW'(1);
            bus_valid_d = 1'b1;
            bus_data_d  = mem_q[rd_ptr_q];
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (port.grant && (count_q == '0)) begin
            spurious_d = 1'b1;
        end

        if (req && !port.grant) begin
            starve_cnt_d = (starve_cnt_q == SW'(STARVE_LIMIT)) ? starve_cnt_q
                                                                : starve_cnt_q + SW'(1);
        end
        starve_d = (starve_cnt_d == SW'(STARVE_LIMIT));
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            bus_valid_q  <= 1'b0;
            bus_data_q   <= '0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
            spurious_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            bus_valid_q  <= bus_valid_d;
            bus_data_q   <= bus_data_d;
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
            spurious_q   <= spurious_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= port.in_data;
        end
    end

    assign port.in_ready  = !reset && !full;
    assign port.req       = req;
    assign port.bus_valid = bus_valid_q;
    assign port.bus_data  = bus_data_q;
    assign port.pending   = count_q;
    assign port.starve    = starve_q;
    assign port.spurious  = spurious_q;
endmodule
